mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port RAM between the CPU controller's memory interface (port 0, instruction fetch and LDR/STR) and a secondary bus master (port 1, loader/DMA). It latches one request at a time and drives the RAM for that request. It returns read data with a one-cycle completion strobe and alternates fairly between the two masters when both contend. It sits between the CPU/loader and the RAM, replacing the CPU's direct `mem_cmd`/address connection.

## Interface
- `AW`, default 8: RAM address width (256 words).
- `DW`, default 16: data word width.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request from master 0 / master 1.
- `cmd0`, `cmd1`  in  2  command: `M_NONE` = 00, `M_READ` = 01, `M_WRITE` = 10, 11 = reserved.
- `addr0`, `addr1`  in  AW  word address.
- `wdata0`, `wdata1`  in  DW  write data.
- `gnt0`, `gnt1`  out  1  the port owns the RAM; held for the whole transaction.
- `done0`, `done1`  out  1  one-cycle completion strobe.
- `rdata`  out  DW  read result; valid in the `done` cycle and held until the next read completes.
- `busy`  out  1  state is not IDLE.
- `ram_addr`  out  AW  RAM address.
- `ram_read`  out  1  RAM read enable.
- `ram_write`  out  1  RAM write enable.
- `ram_din`  out  DW  RAM write data.
- `ram_dout`  in  DW  RAM read data, registered and valid one cycle after `ram_read`.

## Operation
- States: IDLE, ACCESS, RDWAIT, DONE.
- State encoding is 2 bits, plus a `last` flag recording the most recently served port.

- IDLE
  - No request: stay in IDLE.
  - Exactly one `req` high: select that port.
  - Both high: select the port that is not `last`.
  - On selection, latch `cmd`, `addr` and `wdata` for the selected port into internal registers, set its `gnt`, and go to ACCESS.

- ACCESS
  - `ram_addr` = latched address.
  - `M_READ`: `ram_read` = 1, go to RDWAIT.
  - `M_WRITE`: `ram_write` = 1 and `ram_din` = latched data, go to DONE.
  - `M_NONE` or 11: no RAM strobe, go to DONE (no-op completion).

- RDWAIT: capture `ram_dout` into `rdata`, go to DONE.

- DONE: pulse `done` for the granted port, update `last` to the served port, clear `gnt`, go to IDLE.

- Request inputs are sampled only in IDLE. Changes to them during a transaction are ignored.
- A requester deasserts `req` on seeing `done`. If `req` is still high at IDLE, it is treated as a new request.
- At most one of `gnt0`/`gnt1` is high at any time; the same holds for `done0`/`done1`.
- `ram_read` and `ram_write` are never high together, and each is high for exactly one cycle per transaction.
- Reset values: state = IDLE, `last` = 1 (so port 0 wins the first contention), and all outputs = 0, including `rdata`, `ram_addr` and `ram_din`.
- Reset asserted mid-transaction aborts it immediately and asynchronously. No `done` is issued. A write that already completed in ACCESS is not rolled back.

## Timing
- Request seen high at clock edge T0 (state IDLE):
  - `gnt` high from T0 until the edge that leaves DONE.
- Write:
  - ACCESS during cycle T0..T1; `ram_write` high in that cycle.
  - DONE in cycle T1..T2; `done` high in that cycle.
  - Latency is 2 cycles.
- Read:
  - ACCESS during T0..T1, RDWAIT during T1..T2, DONE during T2..T3.
  - `rdata` is valid from T2 onward.
  - Latency is 3 cycles.
- No-op: 2 cycles, no RAM strobe.
- Back-to-back: one mandatory IDLE cycle between transactions.
  - Minimum period: 3 cycles per write, 4 cycles per read.
- Under continuous two-port contention, grants strictly alternate, so neither port waits more than one transaction.
- All outputs are registered or decoded from state plus latched registers. There is no combinational path from `req`/`cmd` to the RAM outputs.

## Structure
- Shared package holds:
  - the `M_NONE`/`M_READ`/`M_WRITE` command constants, also used by the CPU controller;
  - the arbiter state encoding;
  - default `AW`/`DW`.
- One natural sub-module: `rr_pick2`.
  - Combinational 2-way round-robin selector.
  - Inputs: `req0`, `req1`, `last`.
  - Outputs: `valid`, `sel`.
- The FSM, latches and RAM drive stay in `mem_arbiter`.

## Test plan
- Reset: hold `reset` = 0 → all outputs 0; release with no requests → `busy` stays 0.
- Port 0 write then read:
  - `req0`, `M_WRITE`, addr 0x05, data 0xBEEF → `ram_write` pulses once with `ram_addr` = 0x05, `ram_din` = 0xBEEF; `done0` 2 cycles after the request edge.
  - Then `M_READ` 0x05 → `rdata` = 0xBEEF with `done0`, 3 cycles after the request edge.
- Contention:
  - `req0` and `req1` both held high with reads of 0x10 / 0x20 → grant order is 0, 1, 0, 1.
  - `gnt0` and `gnt1` are never high together, and each `done` matches its own address data.
- Request-change immunity: change `addr1` from 0x20 to 0x30 during ACCESS → RAM still sees 0x20.
- No-op: `req1` with cmd 00 or 11 → `done1` after 2 cycles; `ram_read` and `ram_write` stay 0.
- Reset mid-read: assert `reset` during RDWAIT → outputs clear asynchronously and no `done`. After release, a new `req1` is served first only if `req0` is low.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_pkg : shared memory command codes, arbiter states, default widths
// Revision 1.0
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int unsigned AW_DEFAULT = 8;
    localparam int unsigned DW_DEFAULT = 16;

    // Memory command codes, shared with the CPU controller's memory interface.
    typedef enum logic [1:0] {
        M_NONE  = 2'b00,
        M_READ  = 2'b01,
        M_WRITE = 2'b10,
        M_RSVD  = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RDWAIT = 2'b10,
        ST_DONE   = 2'b11
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 : combinational two-way round-robin selector (sel = chosen port)
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic sel
);

    always_comb begin
        valid = req0 | req1;
        // On contention favour the port that was not served most recently.
        if (req0 && req1) begin
            sel = ~last;
        end else begin
            sel = req1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : two-master arbiter in front of a single-port synchronous RAM
// Revision 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    cmd0,
    input  logic [1:0]    cmd1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_read,
    output logic          ram_write,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    arb_state_e    state_q, state_d;
    logic          last_q,  last_d;
    logic          sel_q,   sel_d;
    logic [1:0]    cmd_q,   cmd_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          pick_valid;
    logic          pick_sel;

    rr_pick2 u_pick (
        .req0  (req0),
        .req1  (req1),
        .last  (last_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    sel_d   = pick_sel;
                    cmd_d   = pick_sel ? cmd1   : cmd0;
                    addr_d  = pick_sel ? addr1  : addr0;
                    wdata_d = pick_sel ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = (cmd_q == M_READ) ? ST_RDWAIT : ST_DONE;
            end
            ST_RDWAIT: begin
                rdata_d = ram_dout;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                last_d  = sel_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // last resets to 1 so port 0 wins the first contention after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            cmd_q   <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Every output decodes from state and latched registers only.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        gnt0      = busy && !sel_q;
        gnt1      = busy &&  sel_q;
        done0     = (state_q == ST_DONE) && !sel_q;
        done1     = (state_q == ST_DONE) &&  sel_q;
        ram_read  = (state_q == ST_ACCESS) && (cmd_q == M_READ);
        ram_write = (state_q == ST_ACCESS) && (cmd_q == M_WRITE);
        ram_addr  = addr_q;
        ram_din   = wdata_q;
        rdata     = rdata_q;
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!reset) !(gnt0 && gnt1));
    a_rw_excl:    assert property (@(posedge clk) disable iff (!reset) !(ram_read && ram_write));

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed stimulus with queued expectations and a monitor
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0, req1;
    logic [1:0]    cmd0, cmd1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, done0, done1, busy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_read, ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .rdata     (rdata),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Synchronous RAM: write on the strobe edge, read data one cycle later.
    logic [DW-1:0] mem [0:255];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_din;
        if (ram_read)  ram_dout <= mem[ram_addr];
    end

    typedef struct {
        int          port;
        bit          chk_rd;
        logic [15:0] rdata;
        int          cyc;
    } done_t;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [15:0] din;
    } ram_t;

    done_t dq[$];
    ram_t  rq[$];

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT strobes the RAM or completes.
    always @(negedge clk) begin : monitor
        ram_t  r;
        done_t d;
        if (gnt0 || gnt1) check("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
        if (ram_read || ram_write) begin
            check("ram_rw_excl", 32'(ram_read & ram_write), 32'd0);
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ram_unexpected: got read=%0b write=%0b addr=0x%0h expected no access (cycle %0d)",
                         ram_read, ram_write, ram_addr, cyc);
            end else begin
                r = rq.pop_front();
                check("ram_write", 32'(ram_write), 32'(r.wr));
                check("ram_addr", 32'(ram_addr), 32'(r.addr));
                if (r.wr) check("ram_din", 32'(ram_din), 32'(r.din));
            end
        end
        if (done0 || done1) begin
            check("done_excl", 32'(done0 & done1), 32'd0);
            if (dq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done0=%0b done1=%0b expected none (cycle %0d)",
                         done0, done1, cyc);
            end else begin
                d = dq.pop_front();
                check("done_port", 32'(done1), 32'(d.port));
                if (d.cyc >= 0) check("done_cycle", 32'(cyc), 32'(d.cyc));
                if (d.chk_rd) check("rdata", 32'(rdata), 32'(d.rdata));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_gnt0"},  32'(gnt0), 32'd0);
        check({tag, "_gnt1"},  32'(gnt1), 32'd0);
        check({tag, "_done0"}, 32'(done0), 32'd0);
        check({tag, "_done1"}, 32'(done1), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_raddr"}, 32'(ram_addr), 32'd0);
        check({tag, "_rread"}, 32'(ram_read), 32'd0);
        check({tag, "_rwrite"}, 32'(ram_write), 32'd0);
        check({tag, "_rdin"},  32'(ram_din), 32'd0);
    endtask

    task automatic wait_dones(input int k);
        int got = 0;
        int t   = 0;
        while (got < k && t < 200) begin
            @(negedge clk);
            if (done0 || done1) got++;
            t++;
        end
        if (got < k) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got %0d completions expected %0d", got, k);
        end
    endtask

    // Called #1 after a rising edge; the request is sampled on the next edge,
    // so completion is seen (negedge) at cyc + 2 for write/no-op, cyc + 3 for read.
    task automatic xact(input int port, input logic [1:0] cmd, input logic [7:0] addr,
                        input logic [15:0] data, input logic [15:0] exp_rd);
        done_t d;
        ram_t  r;
        d.port   = port;
        d.chk_rd = (cmd == M_READ);
        d.rdata  = exp_rd;
        d.cyc    = cyc + ((cmd == M_READ) ? 3 : 2);
        dq.push_back(d);
        if (cmd == M_READ || cmd == M_WRITE) begin
            r.wr   = (cmd == M_WRITE);
            r.addr = addr;
            r.din  = data;
            rq.push_back(r);
        end
        if (port == 0) begin
            req0 = 1'b1; cmd0 = cmd; addr0 = addr; wdata0 = data;
        end else begin
            req1 = 1'b1; cmd1 = cmd; addr1 = addr; wdata1 = data;
        end
        wait_dones(1);
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    function automatic done_t mk_done(input int port, input logic [15:0] rd, input int c);
        done_t d;
        d.port = port; d.chk_rd = 1'b1; d.rdata = rd; d.cyc = c;
        return d;
    endfunction

    function automatic ram_t mk_rd(input logic [7:0] a);
        ram_t r;
        r.wr = 1'b0; r.addr = a; r.din = 16'h0;
        return r;
    endfunction

    initial begin
        int n;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        cmd0 = 2'b00; cmd1 = 2'b00;
        addr0 = '0; addr1 = '0;
        wdata0 = '0; wdata1 = '0;

        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("busy_idle", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

        xact(0, M_WRITE, 8'h05, 16'hBEEF, 16'h0000);
        xact(0, M_READ,  8'h05, 16'h0000, 16'hBEEF);
        xact(0, M_WRITE, 8'h10, 16'h1111, 16'h0000);
        xact(1, M_WRITE, 8'h20, 16'h2222, 16'h0000);

        // Continuous contention with last = 1: order 0,1,0,1 at a 4-cycle period.
        n = cyc;
        dq.push_back(mk_done(0, 16'h1111, n + 3));
        dq.push_back(mk_done(1, 16'h2222, n + 7));
        dq.push_back(mk_done(0, 16'h1111, n + 11));
        dq.push_back(mk_done(1, 16'h2222, n + 15));
        rq.push_back(mk_rd(8'h10));
        rq.push_back(mk_rd(8'h20));
        rq.push_back(mk_rd(8'h10));
        rq.push_back(mk_rd(8'h20));
        req0 = 1'b1; cmd0 = M_READ; addr0 = 8'h10;
        req1 = 1'b1; cmd1 = M_READ; addr1 = 8'h20;
        wait_dones(4);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        // Address change during ACCESS must not reach the RAM.
        mem[8'h30] = 16'h3333;
        n = cyc;
        dq.push_back(mk_done(1, 16'h2222, n + 3));
        rq.push_back(mk_rd(8'h20));
        req1 = 1'b1; cmd1 = M_READ; addr1 = 8'h20;
        @(posedge clk); #1;
        addr1 = 8'h30;
        wait_dones(1);
        @(posedge clk); #1;
        req1 = 1'b0;

        xact(1, M_NONE, 8'h44, 16'h5555, 16'h0000);
        xact(1, M_RSVD, 8'h44, 16'h5555, 16'h0000);
        xact(0, M_NONE, 8'h00, 16'h0000, 16'h0000);

        // Abort a read in RDWAIT; the ACCESS-cycle read strobe still occurs.
        rq.push_back(mk_rd(8'h05));
        req0 = 1'b1; cmd0 = M_READ; addr0 = 8'h05;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        req0  = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // last was 0 before the abort; reset must restore 1 so port 0 wins.
        n = cyc;
        dq.push_back(mk_done(0, 16'hBEEF, n + 3));
        dq.push_back(mk_done(1, 16'h2222, n + 7));
        rq.push_back(mk_rd(8'h05));
        rq.push_back(mk_rd(8'h20));
        req0 = 1'b1; cmd0 = M_READ; addr0 = 8'h05;
        req1 = 1'b1; cmd1 = M_READ; addr1 = 8'h20;
        wait_dones(2);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;

        xact(1, M_READ, 8'h10, 16'h0000, 16'h1111);

        repeat (3) @(posedge clk);
        #1;
        check("done_queue_empty", 32'(dq.size()), 32'd0);
        check("ram_queue_empty",  32'(rq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
